// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between the fetch and data stages.
// Define ARB_ROUND_ROBIN_EN to alternate grants under contention instead of fixed data priority.
module mem_port_arbiter #(
    parameter int ADDRBITS = 16,
    parameter int DBITS    = 16,
    parameter int MEM_LAT  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_if_req,
    input  logic [ADDRBITS-1:0] i_if_addr,
    output logic                o_if_ack,
    output logic [DBITS-1:0]    o_if_rdata,
    input  logic                i_d_req,
    input  logic                i_d_we,
    input  logic [ADDRBITS-1:0] i_d_addr,
    input  logic [DBITS-1:0]    i_d_wdata,
    output logic                o_d_ack,
    output logic [DBITS-1:0]    o_d_rdata,
    output logic                o_mem_en,
    output logic                o_mem_we,
    output logic [ADDRBITS-1:0] o_mem_addr,
    output logic [DBITS-1:0]    o_mem_wdata,
    input  logic [DBITS-1:0]    i_mem_rdata,
    output logic                o_stall_if,
    output logic                o_stall_d
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t     r_state, w_next;
    logic       r_owner;
    logic       r_we;
    logic [3:0] r_cnt;
    logic       w_any, w_grant_d;

    assign w_any      = i_if_req | i_d_req;
    assign o_stall_if = i_if_req & ~o_if_ack;
    assign o_stall_d  = i_d_req & ~o_d_ack;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_d;
    assign w_grant_d = i_d_req & (~i_if_req | ~r_last_d);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_last_d <= 1'b1;
        else if (r_state == IDLE && w_any) r_last_d <= w_grant_d;
`else
    assign w_grant_d = i_d_req;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = r_cnt == 4'd0 ? RESP : WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_cnt       <= 4'd0;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_if_ack    <= 1'b0;
            o_d_ack     <= 1'b0;
            o_if_rdata  <= '0;
            o_d_rdata   <= '0;
        end else begin
            o_mem_en <= 1'b0;
            o_mem_we <= 1'b0;
            o_if_ack <= 1'b0;
            o_d_ack  <= 1'b0;
            case (r_state)
                IDLE: if (w_any) begin
                    r_owner     <= w_grant_d;
                    r_we        <= w_grant_d & i_d_we;
                    o_mem_en    <= 1'b1;
                    o_mem_we    <= w_grant_d & i_d_we;
                    o_mem_addr  <= w_grant_d ? i_d_addr : i_if_addr;
                    o_mem_wdata <= w_grant_d ? i_d_wdata : o_mem_wdata;
                end
                ISSUE: r_cnt <= 4'(MEM_LAT - 1);
                WAIT: if (r_cnt == 4'd0) begin
                    // stores complete at the same latency but leave the load register untouched
                    if (r_owner & ~r_we) o_d_rdata <= i_mem_rdata;
                    if (~r_owner) o_if_rdata <= i_mem_rdata;
                    o_if_ack <= ~r_owner;
                    o_d_ack  <= r_owner;
                end else r_cnt <= r_cnt - 4'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized self-checking bench; instances run with MEM_LAT 2, 1 and 15.
// Expectations come from the access timing rules and a reference memory image kept here.
module tb_mem_port_arbiter;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int checks = 0, errors = 0;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [2:0] mem_en, mem_we, if_ack, d_ack, stall_if, stall_d;
    logic [2:0][15:0] mem_addr, mem_wdata, mem_rdata, if_rdata, d_rdata;
    logic [15:0] mem [3][256];
    logic [15:0] ref_mem [256];
    int cd [3];
    logic [7:0] ra [3];

    function automatic int lat(input int i);
        return i == 0 ? 2 : i == 1 ? 1 : 15;
    endfunction

    function automatic logic [15:0] init_word(input int a);
        return 16'(a * 40503) ^ 16'h5A5A;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_port_arbiter #(.ADDRBITS(16), .DBITS(16), .MEM_LAT(g == 0 ? 2 : g == 1 ? 1 : 15)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack[g]), .o_if_rdata(if_rdata[g]),
            .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
            .o_d_ack(d_ack[g]), .o_d_rdata(d_rdata[g]),
            .o_mem_en(mem_en[g]), .o_mem_we(mem_we[g]), .o_mem_addr(mem_addr[g]),
            .o_mem_wdata(mem_wdata[g]), .i_mem_rdata(mem_rdata[g]),
            .o_stall_if(stall_if[g]), .o_stall_d(stall_d[g])
        );
    end

    // memory model: read data is valid only in the cycle MEM_LAT after mem_en, garbage otherwise
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                for (int j = 0; j < 256; j++) mem[i][j] <= init_word(j);
                cd[i] <= 0;
                mem_rdata[i] <= 16'($urandom);
            end else begin
                if (mem_en[i] && mem_we[i]) mem[i][mem_addr[i][7:0]] <= mem_wdata[i];
                if (mem_en[i] && !mem_we[i]) ra[i] <= mem_addr[i][7:0];
                cd[i] <= (mem_en[i] && !mem_we[i]) ? lat(i) : (cd[i] > 0 ? cd[i] - 1 : 0);
                mem_rdata[i] <= cd[i] == 1 ? mem[i][ra[i]] : 16'($urandom);
            end
        end
    end

    task automatic ref_init();
        for (int j = 0; j < 256; j++) ref_mem[j] = init_word(j);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_init();
        @(negedge clk);
    endtask

    // drives one access on instance 0 starting in an IDLE cycle and reports what it observed
    task automatic txn(input bit d, input bit we, input logic [15:0] a, input logic [15:0] wd,
                       output int t_en, output int t_ack, output int n_en,
                       output logic [15:0] e_addr, output logic [15:0] e_wd, output logic [15:0] rd,
                       output logic e_we, output bit st_ok);
        int c0 = cyc;
        t_en = -1; t_ack = -1; n_en = 0; st_ok = 1'b1;
        e_addr = 'x; e_wd = 'x; rd = 'x; e_we = 1'bx;
        if (d) begin d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; end
        else begin if_req = 1'b1; if_addr = a; end
        for (int k = 0; k < 40 && t_ack < 0; k++) begin
            #1;
            if (mem_en[0]) begin
                n_en++;
                if (t_en < 0) begin t_en = cyc - c0; e_addr = mem_addr[0]; e_wd = mem_wdata[0]; e_we = mem_we[0]; end
            end
            if (d ? d_ack[0] : if_ack[0]) begin
                t_ack = cyc - c0;
                rd = d ? d_rdata[0] : if_rdata[0];
                if ((d ? stall_d[0] : stall_if[0]) !== 1'b0) st_ok = 1'b0;
                if (d) d_req = 1'b0; else if_req = 1'b0;
            end else if ((d ? stall_d[0] : stall_if[0]) !== 1'b1) st_ok = 1'b0;
            @(negedge clk);
        end
        if (d) d_req = 1'b0; else if_req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({mem_en[i], mem_we[i], if_ack[i], d_ack[i], mem_addr[i], mem_wdata[i], if_rdata[i], d_rdata[i]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got en=%b we=%b ack=%b%b addr=%h wd=%h ifr=%h dr=%h expected all zero",
                         i, mem_en[i], mem_we[i], if_ack[i], d_ack[i], mem_addr[i], mem_wdata[i], if_rdata[i], d_rdata[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        ref_init();
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_en, stall_if, stall_d} !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: got en=%b sif=%b sd=%b expected 0", mem_en, stall_if, stall_d);
        end
    endtask

    task automatic test_fetch();
        int t_en, t_ack, n_en; logic [15:0] ea, ew, rd, a; logic we; bit st;
        for (int n = 0; n < 4; n++) begin
            a = 16'($urandom);
            txn(1'b0, 1'b0, a, 16'h0, t_en, t_ack, n_en, ea, ew, rd, we, st);
            checks++; if (t_en !== 1 || n_en !== 1) begin errors++; $display("FAIL fetch_en: got cycle %0d count %0d expected 1 and 1", t_en, n_en); end
            checks++; if (ea !== a || we !== 1'b0) begin errors++; $display("FAIL fetch_port: got addr %h we %b expected %h 0", ea, we, a); end
            checks++; if (t_ack !== 4) begin errors++; $display("FAIL fetch_ack_lat: got %0d expected 4", t_ack); end
            checks++; if (rd !== ref_mem[a[7:0]]) begin errors++; $display("FAIL fetch_rdata: got %h expected %h", rd, ref_mem[a[7:0]]); end
            checks++; if (!st) begin errors++; $display("FAIL fetch_stall: got bad stall_if expected 1 until ack then 0"); end
        end
    endtask

    task automatic test_store();
        int t_en, t_ack, n_en; logic [15:0] ea, ew, rd, a, wd, prev; logic we; bit st;
        for (int n = 0; n < 3; n++) begin
            a  = n == 0 ? 16'h0040 : 16'($urandom);
            wd = n == 0 ? 16'hBEEF : 16'($urandom);
            prev = d_rdata[0];
            txn(1'b1, 1'b1, a, wd, t_en, t_ack, n_en, ea, ew, rd, we, st);
            ref_mem[a[7:0]] = wd;
            checks++; if (we !== 1'b1 || ew !== wd || ea !== a || n_en !== 1) begin errors++; $display("FAIL store_port: got we %b wd %h addr %h pulses %0d expected 1 %h %h 1", we, ew, ea, n_en, wd, a); end
            checks++; if (t_ack !== 4 || !st) begin errors++; $display("FAIL store_ack: got lat %0d stall_ok %b expected 4 1", t_ack, st); end
            checks++; if (d_rdata[0] !== prev) begin errors++; $display("FAIL store_rdata_held: got %h expected %h", d_rdata[0], prev); end
            txn(1'b1, 1'b0, a, 16'h0, t_en, t_ack, n_en, ea, ew, rd, we, st);
            checks++; if (rd !== wd || we !== 1'b0 || t_ack !== 4) begin errors++; $display("FAIL load_back: got %h we %b lat %0d expected %h 0 4", rd, we, t_ack, wd); end
            txn(1'b0, 1'b0, a, 16'h0, t_en, t_ack, n_en, ea, ew, rd, we, st);
            checks++; if (rd !== wd) begin errors++; $display("FAIL fetch_after_store: got %h expected %h", rd, wd); end
        end
    endtask

    task automatic test_contention();
        int t_en, t_ack, n_en, c0, td, tf; logic [15:0] ea, ew, rd, ad, af, rdd, rdf; logic we; bit st, last_d, first_d;
        do_reset();
        last_d = 1'b1;
        for (int r = 0; r < 3; r++) begin
            if (r == 1) begin
                txn(1'b0, 1'b0, 16'($urandom), 16'h0, t_en, t_ack, n_en, ea, ew, rd, we, st);
                last_d = 1'b0;
            end
            ad = 16'($urandom); af = 16'($urandom);
            td = -1; tf = -1; rdd = 'x; rdf = 'x;
            c0 = cyc;
            d_req = 1'b1; d_we = 1'b0; d_addr = ad; if_req = 1'b1; if_addr = af;
            for (int k = 0; k < 40 && (td < 0 || tf < 0); k++) begin
                #1;
                if (d_ack[0]) begin td = cyc - c0; rdd = d_rdata[0]; d_req = 1'b0; end
                if (if_ack[0]) begin tf = cyc - c0; rdf = if_rdata[0]; if_req = 1'b0; end
                @(negedge clk);
            end
            d_req = 1'b0; if_req = 1'b0;
            first_d = RR ? !last_d : 1'b1;
            checks++; if (td !== (first_d ? 4 : 9)) begin errors++; $display("FAIL contend_d_ack[%0d]: got %0d expected %0d", r, td, first_d ? 4 : 9); end
            checks++; if (tf !== (first_d ? 9 : 4)) begin errors++; $display("FAIL contend_if_ack[%0d]: got %0d expected %0d", r, tf, first_d ? 9 : 4); end
            checks++; if (rdd !== ref_mem[ad[7:0]] || rdf !== ref_mem[af[7:0]]) begin errors++; $display("FAIL contend_rdata[%0d]: got %h %h expected %h %h", r, rdd, rdf, ref_mem[ad[7:0]], ref_mem[af[7:0]]); end
            last_d = !first_d;
        end
    endtask

    task automatic test_latency();
        int t [3]; logic [15:0] rd [3]; logic [15:0] a; int c0;
        do_reset();
        a = 16'($urandom);
        for (int i = 0; i < 3; i++) t[i] = -1;
        c0 = cyc;
        if_req = 1'b1; if_addr = a;
        for (int k = 0; k < 25; k++) begin
            #1;
            for (int i = 0; i < 3; i++) if (if_ack[i] && t[i] < 0) begin t[i] = cyc - c0; rd[i] = if_rdata[i]; end
            @(negedge clk);
        end
        if_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (t[i] !== lat(i) + 2) begin errors++; $display("FAIL latency_ack[lat=%0d]: got %0d expected %0d", lat(i), t[i], lat(i) + 2); end
            checks++; if (rd[i] !== ref_mem[a[7:0]]) begin errors++; $display("FAIL latency_rdata[lat=%0d]: got %h expected %h", lat(i), rd[i], ref_mem[a[7:0]]); end
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        int t_en, t_ack, n_en; logic [15:0] ea, ew, rd, a; logic we; bit st, seen;
        a = 16'($urandom) | 16'h0101;
        if_req = 1'b1; if_addr = a;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mem_addr[0] !== a || mem_en[0] !== 1'b0) begin errors++; $display("FAIL wait_hold: got addr %h en %b expected %h 0", mem_addr[0], mem_en[0], a); end
        rst_n = 1'b0;
        #1;
        checks++; if ({mem_en[0], mem_we[0], if_ack[0], d_ack[0], mem_addr[0], if_rdata[0]} !== '0) begin errors++; $display("FAIL async_reset: got en %b ack %b addr %h ifr %h expected zero", mem_en[0], if_ack[0], mem_addr[0], if_rdata[0]); end
        if_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ref_init();
        seen = 1'b0;
        repeat (8) begin @(negedge clk); #1; if (if_ack[0] || d_ack[0] || mem_en[0]) seen = 1'b1; end
        @(negedge clk);
        checks++; if (seen) begin errors++; $display("FAIL no_ack_after_reset: got activity 1 expected 0"); end
        txn(1'b0, 1'b0, a, 16'h0, t_en, t_ack, n_en, ea, ew, rd, we, st);
        checks++; if (t_ack !== 4 || rd !== ref_mem[a[7:0]]) begin errors++; $display("FAIL reissue: got lat %0d data %h expected 4 %h", t_ack, rd, ref_mem[a[7:0]]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a [4]; int n = 0, prev_en = -1;
        for (int i = 0; i < 4; i++) a[i] = 16'($urandom);
        if_req = 1'b1; if_addr = a[0];
        for (int k = 0; k < 60 && n < 4; k++) begin
            #1;
            if (mem_en[0]) begin
                if (prev_en >= 0) begin
                    checks++; if (cyc - prev_en !== 5) begin errors++; $display("FAIL b2b_spacing: got %0d expected 5", cyc - prev_en); end
                end
                prev_en = cyc;
            end
            if (if_ack[0]) begin
                checks++; if (if_rdata[0] !== ref_mem[a[n][7:0]]) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", n, if_rdata[0], ref_mem[a[n][7:0]]); end
                n++;
                if (n < 4) if_addr = a[n]; else if_req = 1'b0;
            end
            @(negedge clk);
        end
        if_req = 1'b0;
        checks++; if (n !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", n); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_latency();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences and shares one single-port, fixed-latency memory between the instruction-fetch stage and the data stage of the 4-bit-opcode pipeline. Data (LW/SW) accesses come from the data stage, which is the instruction furthest along the pipe. The block grants one requester at a time, drives the memory port, returns read data with a one-cycle ack, and raises per-stage stall signals to the existing hazard/noop logic while a request is outstanding.

Parameters:
ADDRBITS, 16, width of memory address.
DBITS, 16, width of memory data.
MEM_LAT, 2, memory read latency in cycles from the mem_en cycle to mem_rdata valid; legal range 1..15.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
if_req  in  1  fetch request, level; held until if_ack.
if_addr  in  ADDRBITS  fetch address; stable while if_req is high.
if_ack  out  1  one-cycle pulse; fetch complete.
if_rdata  out  DBITS  fetched word; valid in the if_ack cycle, held until the next ack.
d_req  in  1  data request, level; held until d_ack.
d_we  in  1  1 = store (SW), 0 = load (LW).
d_addr  in  ADDRBITS  data address.
d_wdata  in  DBITS  store data.
d_ack  out  1  one-cycle pulse; data access complete.
d_rdata  out  DBITS  load data; valid in the d_ack cycle, held.
mem_en  out  1  memory access strobe, one cycle per access.
mem_we  out  1  memory write enable; qualified by mem_en.
mem_addr  out  ADDRBITS  memory address.
mem_wdata  out  DBITS  memory write data.
mem_rdata  in  DBITS  memory read data; valid MEM_LAT cycles after mem_en.
stall_if  out  1  combinational: if_req & ~if_ack.
stall_d  out  1  combinational: d_req & ~d_ack.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_en, mem_we, if_ack, d_ack = 0; mem_addr, mem_wdata, if_rdata, d_rdata, owner, and counter = 0. Any in-flight access is dropped without an ack.
- All outputs except stall_if and stall_d are registered.
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE: requests are sampled only in this state.
  - If any request is pending, latch owner (arbitration below), latch the address, we, and wdata into the mem_* registers, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: mem_en=1 for exactly this cycle. mem_we=d_we if owner is data, 0 if owner is fetch. Load counter with MEM_LAT-1, then go to WAIT.
- WAIT: mem_en=0 and mem_we=0; mem_addr is held.
  - When counter==0, capture mem_rdata into if_rdata or d_rdata per owner and go to RESP.
  - Otherwise decrement the counter.
  - The mem_rdata valid cycle is therefore the last WAIT cycle, which is the ISSUE cycle + MEM_LAT.
- RESP: assert the owner's ack for one cycle, then go to IDLE.
  - For stores, the rdata register is not updated; the ack still fires at the same latency.
- Latency: request sampled in IDLE cycle t → mem_en in cycle t+1 → ack in cycle t+MEM_LAT+2. Next sample in cycle t+MEM_LAT+3.
- Throughput: one access per MEM_LAT+3 cycles.
- Arbitration (default): d_req has fixed priority over if_req when both are high in an IDLE cycle.
- The requester may drop or re-present req in the cycle after its ack. No re-grant is possible during RESP, so no masking is needed.
- Request dropped before ack: protocol violation; the access still completes and the ack still pulses.
- Counter width is 4 bits; MEM_LAT=1 means a single WAIT cycle.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: a last_owner flop (reset value: data) is added. When both requests are high in IDLE, grant the requester that was not served last. A single requester is always granted immediately.
- Undefined: fixed data priority as above; the last_owner flop is absent.

Test Plan:
- Fetch read, MEM_LAT=2: if_req=1, if_addr=0x0040 in IDLE cycle 0; memory returns 0xBEEF → mem_en=1, mem_we=0, mem_addr=0x0040 in cycle 1; if_ack=1, if_rdata=0xBEEF in cycle 4; stall_if=1 in cycles 0-3, 0 in cycle 4.
- Store: d_req=1, d_we=1, d_addr=0x0010, d_wdata=0x1234 → mem_en=1, mem_we=1, mem_wdata=0x1234 for one cycle; d_ack in cycle 4; d_rdata unchanged.
- Contention: if_req and d_req both high in cycle 0, both held → data is served first (d_ack in cycle 4); fetch is sampled in cycle 5 (if_ack in cycle 9). With ARB_ROUND_ROBIN_EN and last_owner=data, fetch is served first.
- MEM_LAT=1 and MEM_LAT=15: a single read → ack exactly in cycle MEM_LAT+2 after the sample cycle; mem_rdata is captured in the correct cycle (rdata toggled off-cycle is not captured).
- Reset mid-operation: rst_n=0 asserted during WAIT → all outputs 0 immediately; no ack after release; a re-issued request completes normally.
- Back-to-back fetch: if_req held continuously with a new address after each ack → mem_en pulses spaced exactly MEM_LAT+3 cycles apart; the correct data is returned for each.
